alu_exec_stage: RTL

- Execute-stage controller that acts as the initiator of the combinational ALU interface.
- Accepts one operation at a time from decode over a valid/ready handshake and drives registered A/B/Sel into the ALU.
- Captures the ALU's Out_0/Out_1 and C/Z/V results one cycle later, then delivers them to the register-file writeback port over a second valid/ready handshake.
- Owns the architectural C/Z/V flag register. MUL returns two writeback beats (low word, then high word).

---
 rtl/alu_exec_stage.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
// alu_exec_stage
// Execute-stage controller that drives a purely combinational ALU.
// One operation is accepted from decode at a time. Its operands and opcode
// are registered onto the ALU inputs, and the ALU results are captured one
// cycle later. The results are then handed to the register-file writeback
// port as one beat, or as two beats for MUL (low word first, then high word).
// This stage also owns the architectural C/Z/V flag register.
//
// Ports
//   clk, rst                      rising-edge clock, async active-high reset
//   in_valid/in_ready             decode handshake; in_ready only in IDLE
//   in_sel,in_a,in_b              ALU opcode and operands
//   in_rd,in_rd_hi                low/high word destinations (rd_hi: MUL only)
//   in_set_flags                  load C/Z/V from this operation
//   alu_a,alu_b,alu_sel           registered ALU inputs
//   alu_out0,alu_out1,alu_c/z/v   combinational ALU results
//   wb_valid/wb_ready             writeback handshake
//   wb_addr,wb_data               writeback beat
//   flag_c,flag_z,flag_v          architectural flags
module alu_exec_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_sel,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [DATA_W-1:0]  in_b,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [RADDR_W-1:0] in_rd_hi,
  input  logic               in_set_flags,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [3:0]         alu_sel,
  input  logic [DATA_W-1:0]  alu_out0,
  input  logic [DATA_W-1:0]  alu_out1,
  input  logic               alu_c,
  input  logic               alu_z,
  input  logic               alu_v,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               flag_c,
  output logic               flag_z,
  output logic               flag_v
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_WB_LO = 2'd2;
  localparam logic [1:0] S_WB_HI = 2'd3;

  localparam logic [3:0] SEL_MUL = 4'd2;

  logic [1:0]         state_q, state_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;
  logic [3:0]         alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0]  res_lo_q, res_lo_d;
  logic [DATA_W-1:0]  res_hi_q, res_hi_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic [RADDR_W-1:0] rd_hi_q, rd_hi_d;
  logic               set_flags_q, set_flags_d;
  logic               flag_c_q, flag_c_d;
  logic               flag_z_q, flag_z_d;
  logic               flag_v_q, flag_v_d;

  // Register 0 is hard-wired, so a beat addressed to it is skipped entirely
  // instead of being presented on the writeback port.
  logic lo_beat;
  logic hi_beat;
  assign lo_beat = (rd_q != '0);
  assign hi_beat = (alu_sel_q == SEL_MUL) && (rd_hi_q != '0);

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    rd_d        = rd_q;
    rd_hi_d     = rd_hi_q;
    set_flags_d = set_flags_q;
    flag_c_d    = flag_c_q;
    flag_z_d    = flag_z_q;
    flag_v_d    = flag_v_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          alu_a_d     = in_a;
          alu_b_d     = in_b;
          alu_sel_d   = in_sel;
          rd_d        = in_rd;
          rd_hi_d     = in_rd_hi;
          set_flags_d = in_set_flags;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        // The ALU has had a full cycle to settle on the registered operands.
        res_lo_d = alu_out0;
        res_hi_d = alu_out1;
        if (set_flags_q) begin
          flag_c_d = alu_c;
          flag_z_d = alu_z;
          flag_v_d = alu_v;
        end
        if (lo_beat) begin
          state_d = S_WB_LO;
        end else if (hi_beat) begin
          state_d = S_WB_HI;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WB_LO: begin
        if (wb_ready) begin
          state_d = hi_beat ? S_WB_HI : S_IDLE;
        end
      end
      S_WB_HI: begin
        if (wb_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      rd_q        <= '0;
      rd_hi_q     <= '0;
      set_flags_q <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_v_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_lo_q    <= res_lo_d;
      res_hi_q    <= res_hi_d;
      rd_q        <= rd_d;
      rd_hi_q     <= rd_hi_d;
      set_flags_q <= set_flags_d;
      flag_c_q    <= flag_c_d;
      flag_z_q    <= flag_z_d;
      flag_v_q    <= flag_v_d;
    end
  end

  // Handshake outputs are decoded from state alone, so they are glitch-free
  // and stay stable while the register file stalls.
  assign in_ready = (state_q == S_IDLE);
  assign wb_valid = (state_q == S_WB_LO) || (state_q == S_WB_HI);
  assign wb_addr  = (state_q == S_WB_HI) ? rd_hi_q  : rd_q;
  assign wb_data  = (state_q == S_WB_HI) ? res_hi_q : res_lo_q;

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_sel = alu_sel_q;
  assign flag_c  = flag_c_q;
  assign flag_z  = flag_z_q;
  assign flag_v  = flag_v_q;

endmodule
